// File: rtl/input_page_feeder.sv
// input_page_feeder
//   Buffers host pages in a small FIFO and feeds them, one per request, to a
//   downstream parity controller. It frames every PAGES pops with a start
//   pulse at the beginning and a frameDone pulse on the last pop.
//
//   Parameters
//     PAGE_W : width of one page (a 5x5 slice)
//     DEPTH  : FIFO depth, power of two, >= 2
//     PAGES  : pages per frame, >= 2
//
//   Ports
//     clk, rst   : clock; asynchronous active-high reset
//     inValid    : host page valid
//     inData     : host page data
//     inReady    : FIFO has room (combinational); a push is inValid & inReady
//     ready      : controller is idle
//     putInput   : controller requests the next page (1-cycle pulse)
//     start      : 1-cycle frame start pulse
//     pageData   : registered page; it updates on every pop in RUN
//     pageIdx    : pages popped so far in the current frame
//     frameDone  : 1-cycle pulse on the last pop of a frame
//     underflow  : sticky flag for a pop from an empty FIFO; only rst clears it
module input_page_feeder #(
   parameter int PAGE_W = 25,
   parameter int DEPTH  = 4,
   parameter int PAGES  = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inValid,
   input  logic [PAGE_W-1:0]        inData,
   output logic                     inReady,
   input  logic                     ready,
   input  logic                     putInput,
   output logic                     start,
   output logic [PAGE_W-1:0]        pageData,
   output logic [$clog2(PAGES)-1:0] pageIdx,
   output logic                     frameDone,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(PAGES);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(PAGES - 1);

   typedef enum logic [1:0] {IDLE, START, RUN, WAIT} state_t;

   state_t              state;
   logic [PAGE_W-1:0]   mem [DEPTH];
   logic [AW-1:0]       wrPtr, rdPtr;
   logic [CW-1:0]       count;
   logic                empty, push, pop, popEff;

   assign empty   = (count == '0);
   assign inReady = (count < DEPTH_C);
   assign push    = inValid && inReady;
   // Requests outside RUN are dropped entirely. An empty pop still counts
   // as a frame pop, but it leaves the FIFO state unchanged.
   assign pop     = putInput && (state == RUN);
   assign popEff  = pop && !empty;

   // The pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push)   wrPtr <= wrPtr + AW'(1);
         if (popEff) rdPtr <= rdPtr + AW'(1);
         case ({push, popEff})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Storage needs no reset: zeroing count and the pointers discards its contents.
   always_ff @(posedge clk) begin
      if (push) mem[wrPtr] <= inData;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         start     <= 1'b0;
         frameDone <= 1'b0;
         pageIdx   <= '0;
         pageData  <= '0;
         underflow <= 1'b0;
      end else begin
         start     <= 1'b0;
         frameDone <= 1'b0;
         case (state)
            IDLE: begin
               if (ready && !empty) begin
                  state <= START;
                  start <= 1'b1;   // start is high exactly while in START
               end
            end
            START: begin
               state   <= RUN;
               pageIdx <= '0;
            end
            RUN: begin
               if (putInput) begin
                  pageData <= empty ? '0 : mem[rdPtr];
                  if (empty) underflow <= 1'b1;
                  if (pageIdx == LAST_IDX) begin
                     pageIdx   <= '0;
                     frameDone <= 1'b1;
                     state     <= WAIT;
                  end else begin
                     pageIdx <= pageIdx + IW'(1);
                  end
               end
            end
            WAIT: begin
               // Passing through IDLE keeps the next start at least two
               // cycles after ready is seen.
               if (ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_input_page_feeder.sv
module tb_input_page_feeder;
   localparam int PAGE_W = 25;
   localparam int DEPTH  = 4;
   localparam int PAGES  = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic              inValid;
   logic [PAGE_W-1:0] inData;
   logic              inReady;
   logic              ready;
   logic              putInput;
   logic              start;
   logic [PAGE_W-1:0] pageData;
   logic [5:0]        pageIdx;
   logic              frameDone;
   logic              underflow;

   int nChecks = 0;
   int nFails  = 0;

   input_page_feeder #(.PAGE_W(PAGE_W), .DEPTH(DEPTH), .PAGES(PAGES)) dut (
      .clk(clk), .rst(rst), .inValid(inValid), .inData(inData), .inReady(inReady),
      .ready(ready), .putInput(putInput), .start(start), .pageData(pageData),
      .pageIdx(pageIdx), .frameDone(frameDone), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; inValid = 1'b0; inData = '0; ready = 1'b0; putInput = 1'b0;
      tick();
      nChecks++;
      if ({start, frameDone, underflow} !== 3'b000) begin
         $display("FAIL reset_flags: got %b expected 000", {start, frameDone, underflow}); nFails++;
      end
      nChecks++;
      if (pageData !== '0 || pageIdx !== 6'd0) begin
         $display("FAIL reset_data: got data=%h idx=%0d expected 0/0", pageData, pageIdx); nFails++;
      end
      nChecks++;
      if (inReady !== 1'b1) begin
         $display("FAIL reset_inReady: got %b expected 1", inReady); nFails++;
      end
      rst = 1'b0;
      tick();
   endtask

   // Fill to DEPTH, check that a 5th page is refused, then start and drain the pages in order.
   task automatic test_fill_order;
      logic [PAGE_W-1:0] pg [4];
      logic              expRdy;
      pg[0] = 25'h0AAAAAA; pg[1] = 25'h0BBBBBB; pg[2] = 25'h0CCCCCC; pg[3] = 25'h0DDDDDD;
      for (int i = 0; i < 4; i++) begin
         inValid = 1'b1; inData = pg[i];
         tick();
         expRdy = (i < 3);
         nChecks++;
         if (inReady !== expRdy) begin
            $display("FAIL fill_inReady[%0d]: got %b expected %b", i, inReady, expRdy); nFails++;
         end
      end
      inData = 25'h0EEEEEE;   // this page must be refused
      tick();
      inValid = 1'b0;
      nChecks++;
      if (inReady !== 1'b0) begin
         $display("FAIL full_inReady: got %b expected 0", inReady); nFails++;
      end
      ready = 1'b1;
      tick();
      nChecks++;
      if (start !== 1'b1) begin
         $display("FAIL fill_start: got %b expected 1", start); nFails++;
      end
      ready = 1'b0;
      tick();
      nChecks++;
      if (start !== 1'b0) begin
         $display("FAIL fill_start_clear: got %b expected 0", start); nFails++;
      end
      for (int i = 0; i < 4; i++) begin
         putInput = 1'b1;
         tick();
         putInput = 1'b0;
         nChecks++;
         if (pageData !== pg[i] || pageIdx !== 6'(i + 1)) begin
            $display("FAIL pop_order[%0d]: got data=%h idx=%0d expected %h/%0d",
                     i, pageData, pageIdx, pg[i], i + 1); nFails++;
         end
         if (i == 0) begin
            nChecks++;
            if (inReady !== 1'b1) begin
               $display("FAIL pop_inReady: got %b expected 1", inReady); nFails++;
            end
         end
      end
   endtask

   // Pop from an empty FIFO, then do a normal pop of 0x1ABCDEF.
   task automatic test_underflow;
      putInput = 1'b1;
      tick();
      putInput = 1'b0;
      nChecks++;
      if (underflow !== 1'b1 || pageData !== '0 || pageIdx !== 6'd5) begin
         $display("FAIL underflow: got uf=%b data=%h idx=%0d expected 1/0/5",
                  underflow, pageData, pageIdx); nFails++;
      end
      inValid = 1'b1; inData = 25'h1ABCDEF;
      tick();
      inValid = 1'b0;
      nChecks++;
      if (underflow !== 1'b1) begin
         $display("FAIL underflow_sticky: got %b expected 1", underflow); nFails++;
      end
      putInput = 1'b1;
      tick();
      putInput = 1'b0;
      nChecks++;
      if (pageData !== 25'h1ABCDEF || pageIdx !== 6'd6) begin
         $display("FAIL pop_head: got data=%h idx=%0d expected 1abcdef/6", pageData, pageIdx); nFails++;
      end
   endtask

   // With 2 pages queued, a cycle with both a push and a pop keeps count at 2.
   task automatic test_push_pop_same;
      logic [PAGE_W-1:0] exp [4];
      exp[0] = 25'h0111111; exp[1] = 25'h0222222; exp[2] = 25'h0333333; exp[3] = '0;
      for (int i = 0; i < 2; i++) begin
         inValid = 1'b1; inData = exp[i];
         tick();
      end
      inData = exp[2]; putInput = 1'b1;
      tick();
      inValid = 1'b0; putInput = 1'b0;
      nChecks++;
      if (pageData !== exp[0] || pageIdx !== 6'd7) begin
         $display("FAIL pushpop: got data=%h idx=%0d expected %h/7", pageData, pageIdx, exp[0]); nFails++;
      end
      // Exactly two more real pages follow, then the FIFO is empty.
      for (int i = 1; i < 4; i++) begin
         putInput = 1'b1;
         tick();
         putInput = 1'b0;
         nChecks++;
         if (pageData !== exp[i] || pageIdx !== 6'(7 + i)) begin
            $display("FAIL pushpop_drain[%0d]: got data=%h idx=%0d expected %h/%0d",
                     i, pageData, pageIdx, exp[i], 7 + i); nFails++;
         end
      end
   endtask

   // After reset, with ready=1 and a single push, start goes high in the cycle after the next edge.
   task automatic test_start_latency;
      rst = 1'b1;
      tick();
      rst = 1'b0; ready = 1'b1;
      tick();
      nChecks++;
      if (start !== 1'b0 || underflow !== 1'b0) begin
         $display("FAIL start_empty: got start=%b uf=%b expected 0/0", start, underflow); nFails++;
      end
      inValid = 1'b1; inData = 25'h0100000;
      tick();
      inValid = 1'b0;
      nChecks++;
      if (start !== 1'b0) begin
         $display("FAIL start_early: got %b expected 0", start); nFails++;
      end
      tick();
      nChecks++;
      if (start !== 1'b1) begin
         $display("FAIL start_pulse: got %b expected 1", start); nFails++;
      end
      ready = 1'b0;
      tick();
      nChecks++;
      if (start !== 1'b0) begin
         $display("FAIL start_width: got %b expected 0", start); nFails++;
      end
   endtask

   // Run a full frame, popping every 3 cycles; each pop cycle also pushes the next page.
   task automatic test_frame;
      logic [PAGE_W-1:0] expData;
      logic              expDone;
      logic [5:0]        expIdx;
      for (int k = 0; k < PAGES; k++) begin
         putInput = 1'b1; inValid = 1'b1; inData = PAGE_W'(32'h100000 + k + 1);
         tick();
         putInput = 1'b0; inValid = 1'b0;
         expData = PAGE_W'(32'h100000 + k);
         expDone = (k == PAGES - 1);
         expIdx  = 6'((k + 1) % PAGES);
         nChecks++;
         if (pageData !== expData || frameDone !== expDone || pageIdx !== expIdx) begin
            $display("FAIL frame_pop[%0d]: got data=%h done=%b idx=%0d expected %h/%b/%0d",
                     k, pageData, frameDone, pageIdx, expData, expDone, expIdx); nFails++;
         end
         for (int j = 0; j < 2; j++) begin
            tick();
            nChecks++;
            if (frameDone !== 1'b0 || start !== 1'b0) begin
               $display("FAIL frame_idle[%0d]: got done=%b start=%b expected 0/0",
                        k, frameDone, start); nFails++;
            end
         end
      end
      nChecks++;
      if (underflow !== 1'b0) begin
         $display("FAIL frame_underflow: got %b expected 0", underflow); nFails++;
      end
      // WAIT ignores requests.
      putInput = 1'b1;
      tick();
      putInput = 1'b0;
      nChecks++;
      if (pageIdx !== 6'd0 || pageData !== 25'h010003F) begin
         $display("FAIL wait_ignore: got data=%h idx=%0d expected 010003f/0", pageData, pageIdx); nFails++;
      end
      ready = 1'b1;
      tick();
      nChecks++;
      if (start !== 1'b0) begin
         $display("FAIL wait_to_idle: got start=%b expected 0", start); nFails++;
      end
      tick();
      nChecks++;
      if (start !== 1'b1) begin
         $display("FAIL restart: got start=%b expected 1", start); nFails++;
      end
      ready = 1'b0;
      tick();
      putInput = 1'b1;
      tick();
      putInput = 1'b0;
      nChecks++;
      if (pageData !== 25'h0100040 || pageIdx !== 6'd1) begin
         $display("FAIL frame2_pop: got data=%h idx=%0d expected 0100040/1", pageData, pageIdx); nFails++;
      end
   endtask

   // Assert reset asynchronously with 3 pages queued mid-frame.
   task automatic test_reset_mid_frame;
      for (int i = 0; i < 3; i++) begin
         inValid = 1'b1; inData = PAGE_W'(32'h0F00000 + i);
         tick();
      end
      inValid = 1'b0;
      #2;
      rst = 1'b1;
      #2;
      nChecks++;
      if (pageIdx !== 6'd0 || pageData !== '0 || {start, frameDone, underflow} !== 3'b000) begin
         $display("FAIL async_reset: got idx=%0d data=%h flags=%b expected 0/0/000",
                  pageIdx, pageData, {start, frameDone, underflow}); nFails++;
      end
      nChecks++;
      if (inReady !== 1'b1) begin
         $display("FAIL async_reset_inReady: got %b expected 1", inReady); nFails++;
      end
      tick();
      rst = 1'b0; ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         nChecks++;
         if (start !== 1'b0) begin
            $display("FAIL post_reset_start[%0d]: got %b expected 0", i, start); nFails++;
         end
      end
      inValid = 1'b1; inData = 25'h0123456;
      tick();
      inValid = 1'b0;
      tick();
      nChecks++;
      if (start !== 1'b1) begin
         $display("FAIL post_reset_restart: got %b expected 1", start); nFails++;
      end
      ready = 1'b0;
      tick();
      putInput = 1'b1;
      tick();
      putInput = 1'b0;
      nChecks++;
      if (pageData !== 25'h0123456 || pageIdx !== 6'd1 || underflow !== 1'b0) begin
         $display("FAIL post_reset_pop: got data=%h idx=%0d uf=%b expected 0123456/1/0",
                  pageData, pageIdx, underflow); nFails++;
      end
   endtask

   initial begin
      test_reset();
      test_fill_order();
      test_underflow();
      test_push_pop_same();
      test_start_latency();
      test_frame();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
